// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map for the UART transmitter
// Holds the serialiser state encoding and the STATUS register bit layout.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t;

  localparam int UART_STATUS_READY_BIT    = 0;
  localparam int UART_STATUS_BUSY_BIT     = 1;
  localparam int UART_STATUS_OVERFLOW_BIT = 2;
  localparam int UART_STATUS_FILL_LSB     = 8;
  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  function automatic logic [31:0] uart_status_pack(input logic ready, input logic busy,
                                                   input logic overflow, input logic [7:0] fill);
    logic [31:0] word;
    word = '0;
    word[UART_STATUS_READY_BIT]    = ready;
    word[UART_STATUS_BUSY_BIT]     = busy;
    word[UART_STATUS_OVERFLOW_BIT] = overflow;
    word[UART_STATUS_FILL_LSB +: 8] = fill;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO feeding the UART serialiser
// Pointers carry an extra wrap bit so full and empty are distinguished without a counter.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count    = wr_ptr_q - rd_ptr_q;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_interface.sv
// rtl/uart_tx_interface.sv - memory-mapped 8N1 UART transmitter (DATA/STATUS registers)
// UART_TX_FIFO_EN selects a FIFO_DEPTH byte FIFO; otherwise a single holding register.
module uart_tx_interface
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_enable,
  input  logic        write_req,
  input  logic        read_req,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  output logic        tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  uart_tx_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             overflow_q, overflow_d;

  logic       push_req, push_ok, drop, pop, empty, full;
  logic [7:0] pop_data, fill;
  logic       unused_bits;

  assign unused_bits = ^{write_data[31:8], byte_enable[3:1]};

  assign push_req = write_req && (addr == UART_REG_DATA) && byte_enable[0];
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

`ifdef UART_TX_FIFO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] fifo_count;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_ok),
    .push_data (write_data[7:0]),
    .pop       (pop),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (full),
    .count     (fifo_count)
  );
  assign fill = 8'(fifo_count);
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (pop) hold_valid_d = 1'b0;
    if (push_ok) begin
      hold_valid_d = 1'b1;
      hold_data_d  = write_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign empty    = !hold_valid_q;
  assign full     = hold_valid_q;
  assign pop_data = hold_data_q;
  assign fill     = {7'b0, hold_valid_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = pop_data;
          cnt_d   = CNT_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          // Chain straight into the next frame so bursts carry no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = pop_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is a registered copy of the line level the next state will drive.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    rvalid_d = read_req;
    rdata_d  = '0;
    if (read_req && (addr == UART_REG_STATUS)) begin
      rdata_d = uart_status_pack(!full, !empty || (state_q != IDLE), overflow_q, fill);
    end
    overflow_d = overflow_q;
    if (read_req && (addr == UART_REG_STATUS)) overflow_d = 1'b0;
    if (drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx              = tx_q;
  assign read_data       = rdata_q;
  assign read_data_valid = rvalid_q;

endmodule

// File: tb/tb_uart_tx_interface.sv
// tb/tb_uart_tx_interface.sv - directed self-checking bench for uart_tx_interface
// Runs at 8 clocks per bit; adapts buffer depth to the UART_TX_FIFO_EN build.
module tb_uart_tx_interface;

  localparam int CLK_FREQ_HZ = 800;
  localparam int BAUD_RATE   = 100;
`ifdef UART_TX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam int NB3 = (DEPTH > 1) ? 3 : 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] write_data = '0;
  logic [3:0]  byte_enable = '0;
  logic        write_req = 1'b0;
  logic        read_req = 1'b0;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  uart_tx_interface #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD_RATE(BAUD_RATE), .FIFO_DEPTH(8)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .addr            (addr),
    .write_data      (write_data),
    .byte_enable     (byte_enable),
    .write_req       (write_req),
    .read_req        (read_req),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .tx              (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic bus(input logic wr, input logic rd, input logic a,
                     input logic [31:0] wd, input logic [3:0] be);
    write_req = wr; read_req = rd; addr = a; write_data = wd; byte_enable = be;
    @(negedge clk);
    write_req = 1'b0; read_req = 1'b0; byte_enable = '0;
  endtask

  task automatic wr_byte(input logic [7:0] b, output int n);
    n = cyc + 1;
    bus(1'b1, 1'b0, 1'b0, {24'h0, b}, 4'b0001);
  endtask

  task automatic rd_check(input logic a, input logic [31:0] exp, input string tag);
    bus(1'b0, 1'b1, a, 32'h0, 4'b0000);
    check({tag, "_vld"}, {31'h0, read_data_valid}, 32'h1);
    check(tag, read_data, exp);
  endtask

  task automatic check_frame(input logic [7:0] b, input int s, input string tag);
    wait_until(s);
    check({tag, "_start_first"}, {31'h0, tx}, 32'h0);
    wait_until(s + 7);
    check({tag, "_start_last"}, {31'h0, tx}, 32'h0);
    for (int k = 1; k <= 9; k++) begin
      wait_until(s + 4 + 8 * k);
      check($sformatf("%s_bit%0d", tag, k), {31'h0, tx}, (k == 9) ? 32'h1 : {31'h0, b[k-1]});
    end
    wait_until(s + 79);
    check({tag, "_stop_last"}, {31'h0, tx}, 32'h1);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check(tag, lows, 0);
  endtask

  initial begin
    int n, n2, s;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_vld", {31'h0, read_data_valid}, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    reset_n = 1'b1;

    // Idle line and reset STATUS
    idle_check(100, "t1_idle_tx");
    rd_check(1'b1, 32'h0000_0001, "t1_status");
    @(negedge clk);
    check("t1_vld_one_cycle", {31'h0, read_data_valid}, 32'h0);
    check("t1_rdata_zero", read_data, 32'h0);

    // Single frame 0xA5
    wr_byte(8'hA5, n);
    s = n + 1;
    check("t2_pre_tx", {31'h0, tx}, 32'h1);
    check_frame(8'hA5, s, "t2_a5");
    wait_until(s + 85);

    // Back-to-back burst
    wr_byte(8'h41, n);
    s = n + 1;
    fork
      begin
        for (int i = 1; i < NB3; i++) wr_byte(8'(32'h41 + i), n2);
        wait_until(s + 99);
        rd_check(1'b1, (DEPTH > 1) ? 32'h0000_0103 : 32'h0000_0003, "t3_status_mid");
      end
      begin
        for (int i = 0; i < NB3; i++)
          check_frame(8'(32'h41 + i), s + 80 * i, $sformatf("t3_f%0d", i));
      end
    join
    wait_until(s + 80 * NB3 + 5);
    rd_check(1'b1, 32'h0000_0001, "t3_status_done");

    // Fill the buffer behind an in-flight frame, then overflow
    wr_byte(8'h11, n);
    s = n + 1;
    fork
      begin
        for (int i = 0; i < DEPTH; i++) wr_byte(8'(32'h20 + i), n2);
        wr_byte(8'h99, n2);
        rd_check(1'b1, (DEPTH << 8) | 32'h6, "t4_ovf_set");
        rd_check(1'b1, (DEPTH << 8) | 32'h2, "t4_ovf_clr");
      end
      begin
        check_frame(8'h11, s, "t4_f0");
        for (int i = 0; i < DEPTH; i++)
          check_frame(8'(32'h20 + i), s + 80 * (i + 1), $sformatf("t4_f%0d", i + 1));
        wait_until(s + 80 * (DEPTH + 1));
        idle_check(100, "t4_dropped_not_sent");
      end
    join

    // Masked write, STATUS write, DATA read
    bus(1'b1, 1'b0, 1'b0, 32'h0000_005A, 4'b1110);
    bus(1'b1, 1'b0, 1'b1, 32'h0000_005A, 4'b0001);
    idle_check(40, "t5_no_frame");
    rd_check(1'b0, 32'h0, "t5_data_read");
    rd_check(1'b1, 32'h0000_0001, "t5_status");

    // Reset during data bit 3
    wr_byte(8'hF0, n);
    s = n + 1;
    wr_byte(8'h0F, n2);
    wait_until(s + 34);
    check("t6_bit3_low", {31'h0, tx}, 32'h0);
    reset_n = 1'b0;
    @(negedge clk);
    check("t6_rst_tx", {31'h0, tx}, 32'h1);
    reset_n = 1'b1;
    rd_check(1'b1, 32'h0000_0001, "t6_status");
    idle_check(100, "t6_idle_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
